mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares a single-beat memory port between the core's instruction bus and data bus. It sits between the core's fetch/memory stages and the external memory interface. It latches one granted request, holds it stable on the memory port until the memory acknowledges it, then routes the response back to the owning requester. Only one transaction is outstanding at a time.

## Interface
- ADDR_W, 64, address width of all request channels
- DATA_W, 64, memory port data width; instruction data is fixed at 32 bits
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  in  1  instruction fetch request; held high until iresp_data_ok
- ireq_addr  in  ADDR_W  fetch address, 4-byte aligned
- iresp_addr_ok  out  1  fetch request accepted (pulses with data_ok)
- iresp_data_ok  out  1  fetch data valid, one-cycle pulse
- iresp_data  out  32  fetched instruction word
- dreq_valid  in  1  data request; held high until dresp_data_ok
- dreq_addr  in  ADDR_W  data address
- dreq_size  in  3  log2 byte count (0..3)
- dreq_strobe  in  8  byte write enables; all-zero means load
- dreq_data  in  DATA_W  store data
- dresp_addr_ok  out  1  data request accepted (pulses with data_ok)
- dresp_data_ok  out  1  data response valid, one-cycle pulse
- dresp_data  out  DATA_W  load data (raw 64-bit beat)
- mreq_valid  out  1  memory request valid
- mreq_is_write  out  1  1 = store
- mreq_addr  out  ADDR_W  memory address
- mreq_size  out  3  log2 byte count
- mreq_strobe  out  8  byte enables
- mreq_data  out  DATA_W  write data
- mresp_ready  in  1  memory completes the current request this cycle
- mresp_data  in  DATA_W  read data, valid when mresp_ready
- busy  out  1  a transaction is outstanding
- owner  out  1  owner of the current transaction: 0 = ibus, 1 = dbus

## Operation
- States:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction latched and outstanding.
- In IDLE with any valid request:
  - Grant one requester.
  - Latch its fields into the request register.
  - Record the owner and go to BUSY.
- Grant policy without the configuration macro: fixed priority, dbus beats ibus.
- Field mapping when ibus is granted: size=3'b010, strobe=0, is_write=0, data=0, addr=ireq_addr.
- Field mapping when dbus is granted: is_write=|dreq_strobe; all other fields copied.
- In BUSY:
  - mreq_* is driven from the latched register and stays stable for the whole transaction.
  - mreq_valid=1.
  - Requester inputs are ignored.
- On mresp_ready in BUSY:
  - The owner's addr_ok and data_ok both pulse for one cycle.
  - The owner's response data takes mresp_data, combinationally in the same cycle.
  - Next state is IDLE.
- iresp_data selects mresp_data[63:32] when the latched addr[2]=1, else mresp_data[31:0].
- Abandoned request: if the owner's valid is low in the completion cycle (pipeline flush), the memory transaction still completes. Its data_ok/addr_ok are suppressed and the response is discarded.
- mresp_ready in IDLE is ignored.
- The non-owner's response outputs are always 0.

## Timing
- Reset (async, immediate) values:
  - state = IDLE.
  - All outputs = 0, including mreq_valid, busy and owner.
  - Round-robin pointer = ibus-last.
- Reset asserted during BUSY aborts the transaction: mreq_valid drops the same cycle and nothing is delivered.
- Grant decided in cycle N (IDLE) → mreq_valid=1 from cycle N+1.
- Completion in cycle M (mresp_ready=1) → data_ok pulse in cycle M → IDLE at M+1 → mreq_valid=0 in M+1.
- Minimum request-to-data_ok latency is 1 cycle (grant in N, memory ready in N+1).
- Back-to-back:
  - The earliest next grant is in M+1, with mreq_valid at M+2.
  - The memory port is idle for at least one cycle between transactions.
- busy = (state == BUSY).
- owner is held from grant until return to IDLE, and reads 0 in IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both requests are valid in IDLE, grant the requester not granted last.
  - The last-grant pointer updates on every grant and resets to ibus, so dbus wins the first tie.
  - A single valid requester is always granted.
- Not defined: fixed dbus priority, and no pointer register exists.

## Test plan
- Single fetch: ireq_valid=1, addr=0x80000004; memory ready after 3 BUSY cycles with mresp_data=0x11112222_33334444 → mreq_size=2 and is_write=0; iresp_data_ok pulses once; iresp_data=0x11112222.
- Store: dreq strobe=0x0F, size=2, data=0xDEADBEEF, addr=0x80001000 → mreq_is_write=1 and mreq_* stable until ready; dresp_data_ok pulses once; iresp outputs stay 0.
- Simultaneous: both requests valid for 3 transactions.
  - Without the macro: grant order d, d, d (dreq re-asserted each time).
  - With ARB_ROUND_ROBIN_EN: grant order d, i, d.
  - In both builds there is one idle cycle between mreq_valid pulses.
- Flush: drop ireq_valid mid-BUSY → mreq_valid stays 1 until mresp_ready; iresp_data_ok stays 0; state returns to IDLE.
- Reset mid-BUSY: assert reset asynchronously → mreq_valid, busy and owner go to 0 without waiting for a clock edge; after release, a new dbus request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing a single-beat memory port between ibus and dbus.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on ties (default: dbus priority).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              mreq_valid,
  output logic              mreq_is_write,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [DATA_W-1:0] mreq_data,
  input  logic              mresp_ready,
  input  logic [DATA_W-1:0] mresp_data,
  output logic              busy,
  output logic              owner
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [7:0]        strobe_q, strobe_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pick_d;
  logic              done;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;  // 0 = ibus granted last, 1 = dbus granted last

  always_comb begin
    pick_d = dreq_valid & (~ireq_valid | ~last_q);
    last_d = last_q;
    if (state_q == S_IDLE && (ireq_valid || dreq_valid)) last_d = pick_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b0;
    else       last_q <= last_d;
  end
`else
  always_comb pick_d = dreq_valid;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (ireq_valid || dreq_valid) begin
          state_d = S_BUSY;
          owner_d = pick_d;
          if (pick_d) begin
            addr_d   = dreq_addr;
            size_d   = dreq_size;
            strobe_d = dreq_strobe;
            data_d   = dreq_data;
          end else begin
            addr_d   = ireq_addr;
            size_d   = 3'b010;
            strobe_d = '0;
            data_d   = '0;
          end
        end
      end
      S_BUSY: begin
        if (mresp_ready) begin
          state_d = S_IDLE;
          owner_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
    end
  end

  assign busy          = (state_q == S_BUSY);
  assign owner         = owner_q;
  assign mreq_valid    = busy;
  assign mreq_is_write = |strobe_q;
  assign mreq_addr     = addr_q;
  assign mreq_size     = size_q;
  assign mreq_strobe   = strobe_q;
  assign mreq_data     = data_q;

  // A requester that dropped valid before completion gets no response.
  assign done          = busy & mresp_ready;
  assign iresp_data_ok = done & ~owner_q & ireq_valid;
  assign iresp_addr_ok = iresp_data_ok;
  assign dresp_data_ok = done & owner_q & dreq_valid;
  assign dresp_addr_ok = dresp_data_ok;
  assign iresp_data    = iresp_data_ok ? (addr_q[2] ? mresp_data[63:32] : mresp_data[31:0]) : '0;
  assign dresp_data    = dresp_data_ok ? mresp_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle plus directed literals.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid = 1'b0;
  logic [63:0] ireq_addr = '0;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid = 1'b0;
  logic [63:0] dreq_addr = '0;
  logic [2:0]  dreq_size = '0;
  logic [7:0]  dreq_strobe = '0;
  logic [63:0] dreq_data = '0;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid, mreq_is_write;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_ready = 1'b0;
  logic [63:0] mresp_data = '0;
  logic        busy, owner;

  int total = 0;
  int bad   = 0;
  int i_pulses = 0;
  int d_pulses = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_is_write(mreq_is_write), .mreq_addr(mreq_addr),
    .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_ready(mresp_ready), .mresp_data(mresp_data),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding transaction record plus the identity of the last winner.
  logic        m_valid = 1'b0;
  logic        m_owner = 1'b0;
  logic [63:0] m_addr = '0;
  logic [2:0]  m_size = '0;
  logic [7:0]  m_strobe = '0;
  logic [63:0] m_data = '0;
  logic        m_last = 1'b0;
  logic        m_take_d;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_owner = 1'b0;
      m_last  = 1'b0;
    end else if (m_valid) begin
      if (mresp_ready) m_valid = 1'b0;
    end else if (ireq_valid || dreq_valid) begin
      if (!ireq_valid)      m_take_d = 1'b1;
      else if (!dreq_valid) m_take_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      else                  m_take_d = (m_last == 1'b0);
`else
      else                  m_take_d = 1'b1;
`endif
      m_last  = m_take_d;
      m_valid = 1'b1;
      m_owner = m_take_d;
      if (m_take_d) begin
        m_addr = dreq_addr; m_size = dreq_size; m_strobe = dreq_strobe; m_data = dreq_data;
      end else begin
        m_addr = ireq_addr; m_size = 3'd2; m_strobe = 8'h00; m_data = 64'h0;
      end
    end
  end

  logic        e_done, e_iok, e_dok;
  logic [31:0] e_idata;
  logic [63:0] e_ddata;

  always @(negedge clk) begin
    e_done  = m_valid && mresp_ready && !reset;
    e_iok   = e_done && !m_owner && ireq_valid;
    e_dok   = e_done && m_owner && dreq_valid;
    e_idata = 32'h0;
    if (e_iok) e_idata = m_addr[2] ? mresp_data[63:32] : mresp_data[31:0];
    e_ddata = e_dok ? mresp_data : 64'h0;
    chk("mreq_valid", mreq_valid, m_valid);
    chk("busy", busy, m_valid);
    chk("owner", owner, m_valid & m_owner);
    if (m_valid) begin
      chk("mreq_addr", mreq_addr, m_addr);
      chk("mreq_size", mreq_size, m_size);
      chk("mreq_strobe", mreq_strobe, m_strobe);
      chk("mreq_data", mreq_data, m_data);
      chk("mreq_is_write", mreq_is_write, |m_strobe);
    end
    chk("iresp_data_ok", iresp_data_ok, e_iok);
    chk("iresp_addr_ok", iresp_addr_ok, e_iok);
    chk("iresp_data", iresp_data, e_idata);
    chk("dresp_data_ok", dresp_data_ok, e_dok);
    chk("dresp_addr_ok", dresp_addr_ok, e_dok);
    chk("dresp_data", dresp_data, e_ddata);
    if (iresp_data_ok === 1'b1) i_pulses++;
    if (dresp_data_ok === 1'b1) d_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(name, busy, 1'b1);
  endtask

  logic exp_order [3];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
`else
    exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1;
`endif
    reset = 1'b1;
    step();
    step();
    chk("rst_mreq_valid", mreq_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_mreq_addr", mreq_addr, 64'h0);
    reset = 1'b0;
    step();

    // Simultaneous requests, both held for three transactions.
    ireq_valid = 1'b1; ireq_addr = 64'h80000010;
    dreq_valid = 1'b1; dreq_addr = 64'h80002000; dreq_size = 3'd3; dreq_strobe = 8'h00;
    for (int t = 0; t < 3; t++) begin
      wait_busy("sim_grant");
      chk("sim_order", owner, exp_order[t]);
      step();
      mresp_ready = 1'b1; mresp_data = 64'hA5A5_0000_0000_0000 + 64'(t);
      step();
      mresp_ready = 1'b0;
      chk("sim_idle_gap", mreq_valid, 1'b0);
    end
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    step();
    step();

    // Single fetch with three waiting BUSY cycles.
    i_pulses = 0;
    ireq_valid = 1'b1; ireq_addr = 64'h80000004;
    step();
    chk("fetch_latency", mreq_valid, 1'b1);
    chk("fetch_size", mreq_size, 3'd2);
    chk("fetch_is_write", mreq_is_write, 1'b0);
    step(); step(); step();
    mresp_ready = 1'b1; mresp_data = 64'h11112222_33334444;
    #1;
    chk("fetch_data_ok", iresp_data_ok, 1'b1);
    chk("fetch_data", iresp_data, 64'h11112222);
    step();
    mresp_ready = 1'b0; ireq_valid = 1'b0;
    step();
    chk("fetch_pulses", i_pulses, 1);

    // Store; requester inputs change mid-transaction and must be ignored.
    d_pulses = 0;
    dreq_valid = 1'b1; dreq_addr = 64'h80001000; dreq_size = 3'd2;
    dreq_strobe = 8'h0F; dreq_data = 64'hDEADBEEF;
    step();
    chk("store_is_write", mreq_is_write, 1'b1);
    dreq_addr = 64'hFFFF0000; dreq_data = 64'h0; dreq_strobe = 8'hFF;
    step(); step();
    chk("store_addr_stable", mreq_addr, 64'h80001000);
    chk("store_data_stable", mreq_data, 64'hDEADBEEF);
    mresp_ready = 1'b1; mresp_data = 64'h0123456789ABCDEF;
    #1;
    chk("store_data_ok", dresp_data_ok, 1'b1);
    chk("store_no_iresp", iresp_data_ok, 1'b0);
    step();
    mresp_ready = 1'b0; dreq_valid = 1'b0; dreq_strobe = 8'h00;
    step();
    chk("store_pulses", d_pulses, 1);

    // Flush: fetch abandoned mid-BUSY.
    i_pulses = 0;
    ireq_valid = 1'b1; ireq_addr = 64'h80000100;
    wait_busy("flush_grant");
    step();
    ireq_valid = 1'b0;
    step();
    chk("flush_still_valid", mreq_valid, 1'b1);
    mresp_ready = 1'b1; mresp_data = 64'hCAFEF00D_12345678;
    #1;
    chk("flush_no_data_ok", iresp_data_ok, 1'b0);
    step();
    chk("flush_idle", busy, 1'b0);
    step();
    mresp_ready = 1'b0;
    chk("flush_pulses", i_pulses, 0);

    // Reset in the middle of a dbus transaction.
    dreq_valid = 1'b1; dreq_addr = 64'h80003000; dreq_size = 3'd3; dreq_strobe = 8'h00;
    wait_busy("rstmid_grant");
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_mreq_valid", mreq_valid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_owner", owner, 1'b0);
    step();
    reset = 1'b0;
    wait_busy("rstmid_regrant");
    chk("rstmid_owner_d", owner, 1'b1);
    mresp_ready = 1'b1; mresp_data = 64'h5555AAAA5555AAAA;
    #1;
    chk("rstmid_data_ok", dresp_data_ok, 1'b1);
    step();
    mresp_ready = 1'b0; dreq_valid = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
